// File: rtl/approx_mul_pipe.sv
// Two-stage approximate unsigned multiplier with a per-quadrant approximation mode.
// S1 holds the post-mode half-width partial products. S2 holds the shift-added product.
module approx_mul_pipe #(
  parameter int W     = 8,
  parameter int TRUNC = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [7:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   prod,
  output logic [CNT_W-1:0] done_count
);

  localparam int H = W / 2;

  // Applies one quadrant's approximation mode to its low TRUNC bits.
  function automatic logic [W-1:0] apply_mode(input logic [W-1:0] p, input logic [1:0] m);
    logic [W-1:0] lo_mask;
    logic [W-1:0] comp;
    lo_mask = '0;
    comp    = '0;
    for (int i = 0; i < W; i++) begin
      lo_mask[i] = (i < TRUNC);
    end
    comp[TRUNC-1] = 1'b1;
    case (m)
      2'd1:    apply_mode = p & ~lo_mask;
      2'd2:    apply_mode = '0;
      2'd3:    apply_mode = (p & ~lo_mask) | comp;
      default: apply_mode = p;
    endcase
  endfunction

  logic [W-1:0]     w_ah, w_al, w_bh, w_bl;
  logic [W-1:0]     w_hh, w_hl, w_lh, w_ll;
  logic             w_s2_load;
  logic             w_accept;
  logic [W:0]       w_mid;
  logic [2*W:0]     w_sum;

  logic             r_vld_p0;
  logic [W-1:0]     r_hh_p0, r_hl_p0, r_lh_p0, r_ll_p0;
  logic             r_vld_p1;
  logic [2*W-1:0]   r_prod_p1;
  logic [CNT_W-1:0] r_done_count;

  // The quadrant operands are zero-extended so that each product is computed at W bits.
  assign w_ah = {{(W-H){1'b0}}, a[W-1:H]};
  assign w_al = {{(W-H){1'b0}}, a[H-1:0]};
  assign w_bh = {{(W-H){1'b0}}, b[W-1:H]};
  assign w_bl = {{(W-H){1'b0}}, b[H-1:0]};

  assign w_hh = apply_mode(w_ah * w_bh, mode[7:6]);
  assign w_hl = apply_mode(w_ah * w_bl, mode[5:4]);
  assign w_lh = apply_mode(w_al * w_bh, mode[3:2]);
  assign w_ll = apply_mode(w_al * w_bl, mode[1:0]);

  assign w_s2_load = !r_vld_p1 || out_ready;
  assign in_ready  = !r_vld_p0 || w_s2_load;
  assign w_accept  = in_valid && in_ready;

  // Stage p0: the multiply and the mode logic, registered as partial products.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_hh_p0  <= '0;
      r_hl_p0  <= '0;
      r_lh_p0  <= '0;
      r_ll_p0  <= '0;
    end else begin
      if (in_ready) begin
        r_vld_p0 <= in_valid;
      end
      if (w_accept) begin
        r_hh_p0 <= w_hh;
        r_hl_p0 <= w_hl;
        r_lh_p0 <= w_lh;
        r_ll_p0 <= w_ll;
      end
    end
  end

  assign w_mid = {1'b0, r_hl_p0} + {1'b0, r_lh_p0};
  assign w_sum = {1'b0, r_hh_p0, {W{1'b0}}}
               + {{(W-H){1'b0}}, w_mid, {H{1'b0}}}
               + {{(W+1){1'b0}}, r_ll_p0};

  // Stage p1: the shift-add result. Any carry out of the top bit is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_prod_p1    <= '0;
      r_done_count <= '0;
    end else begin
      if (w_s2_load) begin
        r_vld_p1 <= r_vld_p0;
        if (r_vld_p0) begin
          r_prod_p1 <= w_sum[2*W-1:0];
        end
      end
      if (r_vld_p1 && out_ready) begin
        r_done_count <= r_done_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign out_valid  = r_vld_p1;
  assign prod       = r_prod_p1;
  assign done_count = r_done_count;

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed bench for approx_mul_pipe at W=8, TRUNC=2, CNT_W=16.
module tb_approx_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [7:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] prod;
  logic [15:0] done_count;

  int errors = 0;
  int checks = 0;

  approx_mul_pipe #(.W(8), .TRUNC(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .prod       (prod),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Presents one transaction and returns once it has been accepted.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tm);
    int k;
    a = ta; b = tb; mode = tm; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    do_reset();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got=%b exp=0", out_valid); end
    checks++;
    if (prod !== 16'h0000) begin errors++; $display("FAIL reset_prod: got=%h exp=0000", prod); end
    checks++;
    if (done_count !== 16'd0) begin errors++; $display("FAIL reset_done_count: got=%0d exp=0", done_count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got=%b exp=1", in_ready); end
  endtask

  task automatic test_exact();
    out_ready = 1'b1;
    send(8'hFF, 8'hFF, 8'h00);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL exact_latency1: out_valid=%b exp=0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || prod !== 16'hFE01) begin
      errors++; $display("FAIL exact_prod: valid=%b prod=%h exp valid=1 prod=FE01", out_valid, prod);
    end
    tick();
    checks++;
    if (done_count !== 16'd1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL exact_done: count=%0d valid=%b exp count=1 valid=0", done_count, out_valid);
    end
  endtask

  task automatic test_truncate();
    send(8'h37, 8'h5A, 8'h55);
    tick();
    checks++;
    if (out_valid !== 1'b1 || prod !== 16'h1004) begin
      errors++; $display("FAIL truncate_prod: valid=%b prod=%h exp valid=1 prod=1004", out_valid, prod);
    end
    tick();
  endtask

  task automatic test_skip_hh();
    send(8'hFF, 8'hFF, 8'h80);
    tick();
    checks++;
    if (out_valid !== 1'b1 || prod !== 16'h1D01) begin
      errors++; $display("FAIL skip_hh_prod: valid=%b prod=%h exp valid=1 prod=1D01", out_valid, prod);
    end
    tick();
  endtask

  task automatic test_compensate();
    send(8'h01, 8'h01, 8'h03);
    tick();
    checks++;
    if (out_valid !== 1'b1 || prod !== 16'h0002) begin
      errors++; $display("FAIL compensate_prod: valid=%b prod=%h exp valid=1 prod=0002", out_valid, prod);
    end
    tick();
    checks++;
    if (done_count !== 16'd4) begin errors++; $display("FAIL compensate_done: got=%0d exp=4", done_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    mode = 8'h00;
    a = 8'd2; b = 8'd3; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got=%b exp=1", in_ready); end
    tick();
    a = 8'd4; b = 8'd5;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got=%b exp=1", in_ready); end
    tick();
    a = 8'd6; b = 8'd7;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || prod !== 16'h0006) begin
        errors++;
        $display("FAIL bp_hold%0d: ready=%b valid=%b prod=%h exp ready=0 valid=1 prod=0006", i, in_ready, out_valid, prod);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || prod !== 16'h0014) begin
      errors++; $display("FAIL bp_out2: valid=%b prod=%h exp valid=1 prod=0014", out_valid, prod);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || prod !== 16'h002A) begin
      errors++; $display("FAIL bp_out3: valid=%b prod=%h exp valid=1 prod=002A", out_valid, prod);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || done_count !== 16'd3) begin
      errors++; $display("FAIL bp_done: valid=%b count=%0d exp valid=0 count=3", out_valid, done_count);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    mode = 8'h00;
    a = 8'd9; b = 8'd9; in_valid = 1'b1;
    tick();
    a = 8'd3; b = 8'd3;
    tick();
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || prod !== 16'h0000 || done_count !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_state: valid=%b prod=%h count=%0d ready=%b exp 0 0000 0 1", out_valid, prod, done_count, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d: valid=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_count_wrap();
    out_ready = 1'b1;
    mode = 8'h00; a = 8'd1; b = 8'd1;
    in_valid = 1'b1;
    repeat (65537) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (done_count !== 16'd1) begin errors++; $display("FAIL count_wrap: got=%0d exp=1", done_count); end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_truncate();
    test_skip_hh();
    test_compensate();
    test_back_to_back();
    test_reset_midflight();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
